// File: rtl/rr_arbiter_n.sv
// N-way valid/ready arbiter with a one-entry registered output stage.
// Round-robin or fixed priority; optional packet locking holds the grant until the tail flit.
module rr_arbiter_n #(
   parameter int NUM_REQ  = 4,
   parameter int WIDTH    = 8,
   parameter int RR_MODE  = 1,
   parameter int LOCK_PKT = 0,
   localparam int IDXW    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [NUM_REQ-1:0]         req_valid,
   input  logic [NUM_REQ*WIDTH-1:0]   req_data,
   input  logic [NUM_REQ-1:0]         req_last,
   output logic [NUM_REQ-1:0]         req_ready,
   output logic                       out_valid,
   output logic [WIDTH-1:0]           out_data,
   output logic [IDXW-1:0]            out_winner,
   output logic                       out_last,
   input  logic                       out_ready
);

   logic [IDXW-1:0]    ptr_r;
   logic               lock_r;
   logic [IDXW-1:0]    lock_idx_r;
   logic               out_valid_r;
   logic [WIDTH-1:0]   out_data_r;
   logic [IDXW-1:0]    out_winner_r;
   logic               out_last_r;

   logic               load_en_s;
   logic [NUM_REQ-1:0] elig_s;
   logic               any_s;
   logic [IDXW-1:0]    grant_s;
   logic               xfer_s;
   logic               ptr_adv_s;
   logic [IDXW-1:0]    ptr_next_s;
   logic [WIDTH-1:0]   data_arr_s [NUM_REQ];

   // First eligible index at or after start, wrapping NUM_REQ-1 -> 0.
   function automatic logic [IDXW-1:0] pick(input logic [NUM_REQ-1:0] e,
                                            input logic [IDXW-1:0]    start);
      logic [IDXW-1:0] idx;
      logic [IDXW-1:0] sel;
      logic            hit;
      sel = '0;
      hit = 1'b0;
      idx = start;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (!hit && e[idx]) begin
            sel = idx;
            hit = 1'b1;
         end
         idx = (idx == IDXW'(NUM_REQ - 1)) ? '0 : idx + IDXW'(1);
      end
      return sel;
   endfunction

   for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign data_arr_s[gi] = req_data[gi*WIDTH +: WIDTH];
   end

   // Eligibility, winner selection and the ready handshake.
   always_comb begin
      load_en_s  = !out_valid_r || out_ready;
      elig_s     = req_valid;
      grant_s    = '0;
      req_ready  = '0;
      ptr_next_s = '0;
      if (lock_r) begin
         elig_s = req_valid & (NUM_REQ'(1) << lock_idx_r);
      end else begin
         elig_s = req_valid;
      end
      any_s = |elig_s;
      if (RR_MODE != 0) begin
         grant_s = pick(elig_s, ptr_r);
      end else begin
         grant_s = pick(elig_s, '0);
      end
      xfer_s = load_en_s && any_s;
      if (xfer_s) begin
         req_ready = NUM_REQ'(1) << grant_s;
      end else begin
         req_ready = '0;
      end
      // A locked multi-flit packet consumes a single round-robin turn.
      ptr_adv_s  = xfer_s && ((LOCK_PKT == 0) || req_last[grant_s]);
      ptr_next_s = (grant_s == IDXW'(NUM_REQ - 1)) ? '0 : grant_s + IDXW'(1);
   end

   // Output stage, rotation pointer and packet lock.
   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid_r  <= 1'b0;
         out_data_r   <= '0;
         out_winner_r <= '0;
         out_last_r   <= 1'b0;
         ptr_r        <= '0;
         lock_r       <= 1'b0;
         lock_idx_r   <= '0;
      end else if (load_en_s) begin
         if (any_s) begin
            out_valid_r  <= 1'b1;
            out_data_r   <= data_arr_s[grant_s];
            out_winner_r <= grant_s;
            out_last_r   <= req_last[grant_s];
            if (LOCK_PKT != 0) begin
               lock_r     <= !req_last[grant_s];
               lock_idx_r <= grant_s;
            end
            if (ptr_adv_s) begin
               ptr_r <= ptr_next_s;
            end
         end else begin
            out_valid_r <= 1'b0;
         end
      end
   end

   assign out_valid  = out_valid_r;
   assign out_data   = out_data_r;
   assign out_winner = out_winner_r;
   assign out_last   = out_last_r;

endmodule

// File: tb/tb_rr_arbiter_n.sv
// Bench for rr_arbiter_n: three configurations share one stimulus stream; directed vector table
// plus randomized traffic checked against a behavioural model of the arbitration rules.
module tb_rr_arbiter_n;

   logic        clk;
   logic        rst;
   logic [3:0]  rv;
   logic [31:0] rd;
   logic [3:0]  rl;
   logic        rordy;

   logic [3:0]  rdy_w [3];
   logic        ov_w  [3];
   logic [7:0]  od_w  [3];
   logic [1:0]  w_w   [3];
   logic        ol_w  [3];

   int n_chk  = 0;
   int n_pass = 0;

   rr_arbiter_n #(.NUM_REQ(4), .WIDTH(8), .RR_MODE(1), .LOCK_PKT(0)) u_rr (
      .clk(clk), .reset(rst), .req_valid(rv), .req_data(rd), .req_last(rl),
      .req_ready(rdy_w[0]), .out_valid(ov_w[0]), .out_data(od_w[0]),
      .out_winner(w_w[0]), .out_last(ol_w[0]), .out_ready(rordy));

   rr_arbiter_n #(.NUM_REQ(4), .WIDTH(8), .RR_MODE(0), .LOCK_PKT(0)) u_fp (
      .clk(clk), .reset(rst), .req_valid(rv), .req_data(rd), .req_last(rl),
      .req_ready(rdy_w[1]), .out_valid(ov_w[1]), .out_data(od_w[1]),
      .out_winner(w_w[1]), .out_last(ol_w[1]), .out_ready(rordy));

   rr_arbiter_n #(.NUM_REQ(4), .WIDTH(8), .RR_MODE(1), .LOCK_PKT(1)) u_lk (
      .clk(clk), .reset(rst), .req_valid(rv), .req_data(rd), .req_last(rl),
      .req_ready(rdy_w[2]), .out_valid(ov_w[2]), .out_data(od_w[2]),
      .out_winner(w_w[2]), .out_last(ol_w[2]), .out_ready(rordy));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural model state, one slot per configuration.
   int         m_rr [3] = '{1, 0, 1};
   int         m_lk [3] = '{0, 0, 1};
   bit         m_ov [3];
   logic [7:0] m_od [3];
   int         m_w  [3];
   bit         m_ol [3];
   int         m_ptr [3];
   bit         m_lock [3];
   int         m_lidx [3];
   bit         mdl_init = 1'b0;

   function automatic int m_grant(int k);
      int idx;
      for (int off = 0; off < 4; off++) begin
         idx = (m_rr[k] != 0) ? (m_ptr[k] + off) % 4 : off;
         if (rv[idx] && (!m_lock[k] || idx == m_lidx[k])) return idx;
      end
      return -1;
   endfunction

   function automatic logic [3:0] m_ready(int k);
      int g;
      g = m_grant(k);
      if (m_ov[k] && !rordy) return 4'b0000;
      if (g < 0) return 4'b0000;
      return 4'(1 << g);
   endfunction

   task automatic model_update();
      int g;
      for (int k = 0; k < 3; k++) begin
         if (rst) begin
            m_ov[k] = 1'b0; m_od[k] = 8'h00; m_w[k] = 0; m_ol[k] = 1'b0;
            m_ptr[k] = 0; m_lock[k] = 1'b0; m_lidx[k] = 0;
         end else if (!m_ov[k] || rordy) begin
            g = m_grant(k);
            if (g >= 0) begin
               m_ov[k] = 1'b1;
               m_od[k] = rd[g*8 +: 8];
               m_w[k]  = g;
               m_ol[k] = rl[g];
               if (m_lk[k] != 0) begin
                  m_lock[k] = !rl[g];
                  m_lidx[k] = g;
               end
               if (m_lk[k] == 0 || rl[g]) m_ptr[k] = (g + 1) % 4;
            end else begin
               m_ov[k] = 1'b0;
            end
         end
      end
      if (rst) mdl_init = 1'b1;
   endtask

   task automatic model_check();
      logic [14:0] act;
      logic [14:0] exp;
      if (mdl_init) begin
         for (int k = 0; k < 3; k++) begin
            act = {rdy_w[k], ov_w[k], od_w[k], w_w[k], ol_w[k]};
            exp = {m_ready(k), m_ov[k], m_od[k], 2'(m_w[k]), m_ol[k]};
            n_chk++;
            if (act === exp) n_pass++;
            else $display("FAIL model dut%0d t=%0t: got rdy/ov/data/win/last=%h want %h",
                          k, $time, act, exp);
         end
      end
   endtask

   task automatic drive(input bit r, input logic [3:0] v, input logic [31:0] d,
                        input logic [3:0] l, input bit o);
      rst = r; rv = v; rd = d; rl = l; rordy = o;
      #1;
   endtask

   task automatic advance();
      @(posedge clk);
      model_update();
      @(negedge clk);
   endtask

   typedef struct {
      bit rst; logic [3:0] v; logic [31:0] d; logic [3:0] l; bit ordy;
      int sel; bit chk; logic [3:0] rdy; bit ov; logic [7:0] od; logic [1:0] w; bit ol;
   } vec_t;
   vec_t tbl[$];

   task automatic av(input bit r, input logic [3:0] v, input logic [31:0] d, input logic [3:0] l,
                     input bit o, input int sel, input bit chk, input logic [3:0] rdy,
                     input bit ov, input logic [7:0] od, input logic [1:0] w, input bit ol);
      vec_t e;
      e.rst = r; e.v = v; e.d = d; e.l = l; e.ordy = o; e.sel = sel; e.chk = chk;
      e.rdy = rdy; e.ov = ov; e.od = od; e.w = w; e.ol = ol;
      tbl.push_back(e);
   endtask

   localparam logic [31:0] DD = 32'hD3D2D1D0;
   localparam logic [31:0] DA = 32'hD3A5D1D0;

   initial begin
      logic [14:0] act;
      logic [14:0] exp;
      int s;
      rst = 1'b1; rv = 4'h0; rd = 32'h0; rl = 4'h0; rordy = 1'b1;

      // Round-robin rotation with all requesters valid.
      av(1, 4'hF, DD, 4'h0, 1, 0, 0, 4'b0000, 0, 8'h00, 2'd0, 0);
      av(0, 4'hF, DD, 4'h0, 1, 0, 1, 4'b0001, 0, 8'h00, 2'd0, 0);
      av(0, 4'hF, DD, 4'h0, 1, 0, 1, 4'b0010, 1, 8'hD0, 2'd0, 0);
      av(0, 4'hF, DD, 4'h0, 1, 0, 1, 4'b0100, 1, 8'hD1, 2'd1, 0);
      av(0, 4'hF, DD, 4'h0, 1, 0, 1, 4'b1000, 1, 8'hD2, 2'd2, 0);
      av(0, 4'hF, DD, 4'h0, 1, 0, 1, 4'b0001, 1, 8'hD3, 2'd3, 0);
      av(0, 4'hF, DD, 4'h0, 1, 0, 1, 4'b0010, 1, 8'hD0, 2'd0, 0);
      // Single requester 2, then 1 and 3 together from ptr=3.
      av(1, 4'h0, DA, 4'h0, 1, 0, 0, 4'b0000, 0, 8'h00, 2'd0, 0);
      av(0, 4'b0100, DA, 4'h0, 1, 0, 1, 4'b0100, 0, 8'h00, 2'd0, 0);
      av(0, 4'b1010, DA, 4'h0, 1, 0, 1, 4'b1000, 1, 8'hA5, 2'd2, 0);
      av(0, 4'b1010, DA, 4'h0, 1, 0, 1, 4'b0010, 1, 8'hD3, 2'd3, 0);
      av(0, 4'b0000, DA, 4'h0, 1, 0, 1, 4'b0000, 1, 8'hD1, 2'd1, 0);
      av(0, 4'b0000, DA, 4'h0, 1, 0, 1, 4'b0000, 0, 8'hD1, 2'd1, 0);
      // Five-cycle stall, then same-cycle accept.
      av(0, 4'b0001, DA, 4'b0001, 0, 0, 1, 4'b0001, 0, 8'hD1, 2'd1, 0);
      for (int i = 0; i < 5; i++)
         av(0, 4'b0001, DA, 4'b0001, 0, 0, 1, 4'b0000, 1, 8'hD0, 2'd0, 1);
      av(0, 4'b0010, DA, 4'b0001, 1, 0, 1, 4'b0010, 1, 8'hD0, 2'd0, 1);
      av(0, 4'b0000, DA, 4'b0001, 1, 0, 1, 4'b0000, 1, 8'hD1, 2'd1, 0);
      // Fixed priority starves requester 3.
      av(1, 4'h0, DD, 4'h0, 1, 1, 0, 4'b0000, 0, 8'h00, 2'd0, 0);
      av(0, 4'b1010, DD, 4'h0, 1, 1, 1, 4'b0010, 0, 8'h00, 2'd0, 0);
      av(0, 4'b1010, DD, 4'h0, 1, 1, 1, 4'b0010, 1, 8'hD1, 2'd1, 0);
      av(0, 4'b1010, DD, 4'h0, 1, 1, 1, 4'b0010, 1, 8'hD1, 2'd1, 0);
      av(0, 4'b1000, DD, 4'h0, 1, 1, 1, 4'b1000, 1, 8'hD1, 2'd1, 0);
      av(0, 4'b0000, DD, 4'h0, 1, 1, 1, 4'b0000, 1, 8'hD3, 2'd3, 0);
      // Packet lock: 3-flit packet from req0 with a 2-cycle gap, req1 waits.
      av(1, 4'h0, DD, 4'h0, 1, 2, 0, 4'b0000, 0, 8'h00, 2'd0, 0);
      av(0, 4'b0011, DD, 4'h0, 1, 2, 1, 4'b0001, 0, 8'h00, 2'd0, 0);
      av(0, 4'b0011, DD, 4'h0, 1, 2, 1, 4'b0001, 1, 8'hD0, 2'd0, 0);
      av(0, 4'b0010, DD, 4'h0, 1, 2, 1, 4'b0000, 1, 8'hD0, 2'd0, 0);
      av(0, 4'b0010, DD, 4'h0, 1, 2, 1, 4'b0000, 0, 8'hD0, 2'd0, 0);
      av(0, 4'b0011, DD, 4'b0001, 1, 2, 1, 4'b0001, 0, 8'hD0, 2'd0, 0);
      av(0, 4'b0011, DD, 4'b0001, 1, 2, 1, 4'b0010, 1, 8'hD0, 2'd0, 1);
      av(0, 4'b0000, DD, 4'h0, 1, 2, 1, 4'b0000, 1, 8'hD1, 2'd1, 0);
      // Reset while locked on req1.
      av(1, 4'b0110, DD, 4'h0, 1, 2, 0, 4'b0000, 0, 8'h00, 2'd0, 0);
      av(0, 4'b0110, DD, 4'b0110, 1, 2, 1, 4'b0010, 0, 8'h00, 2'd0, 0);
      av(0, 4'b0110, DD, 4'b0110, 1, 2, 1, 4'b0100, 1, 8'hD1, 2'd1, 1);
      av(0, 4'b0000, DD, 4'h0, 1, 2, 1, 4'b0000, 1, 8'hD2, 2'd2, 1);

      @(negedge clk);
      for (int i = 0; i < tbl.size(); i++) begin
         drive(tbl[i].rst, tbl[i].v, tbl[i].d, tbl[i].l, tbl[i].ordy);
         if (tbl[i].chk) begin
            s   = tbl[i].sel;
            act = {rdy_w[s], ov_w[s], od_w[s], w_w[s], ol_w[s]};
            exp = {tbl[i].rdy, tbl[i].ov, tbl[i].od, tbl[i].w, tbl[i].ol};
            n_chk++;
            if (act === exp) n_pass++;
            else $display("FAIL vec%0d dut%0d: got rdy/ov/data/win/last=%h want %h",
                          i, s, act, exp);
         end
         model_check();
         advance();
      end

      // Randomized traffic against the model.
      for (int i = 0; i < 3000; i++) begin
         drive($urandom_range(99) == 0, 4'($urandom), $urandom, 4'($urandom),
               $urandom_range(3) != 0);
         model_check();
         advance();
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/rr_arbiter_n.md
Name: rr_arbiter_n

Overview:
Clocked N-way arbiter with payload, the successor to the 2-input rotating-priority channel arbiter. It selects one of NUM_REQ valid/ready requesters per transfer and forwards that requester's data and index through a one-entry registered output stage. It supports round-robin or fixed priority, and optional packet locking that holds the grant until the tail flit. It sits at router input/output merge points, ahead of the crossbar.

Parameters:
NUM_REQ, 4, number of requester channels (>=2)
WIDTH, 8, payload width per requester
RR_MODE, 1, 1 = round-robin rotating priority; 0 = fixed priority (index 0 highest)
LOCK_PKT, 0, 1 = grant held from the first flit until a flit with req_last=1; 0 = per-flit arbitration
IDXW, derived = max(1, clog2(NUM_REQ)), width of winner index (localparam)

Ports:
clk  in  1  single clock; all state updates on the rising edge
reset  in  1  synchronous, active-high reset
req_valid  in  NUM_REQ  per-requester valid
req_data  in  NUM_REQ*WIDTH  payloads; requester i occupies bits [i*WIDTH +: WIDTH]
req_last  in  NUM_REQ  tail-flit marker per requester (ignored when LOCK_PKT=0)
req_ready  out  NUM_REQ  one-hot or zero; requester i transfers when req_valid[i] & req_ready[i]
out_valid  out  1  output register holds a flit
out_data  out  WIDTH  granted payload
out_winner  out  IDXW  index of the requester that supplied out_data
out_last  out  1  copy of req_last of the granted flit
out_ready  in  1  downstream accepts when out_valid & out_ready

Behaviour:
- Reset (synchronous, dominates): out_valid=0, out_data=0, out_winner=0, out_last=0, ptr=0, lock=0, lock_idx=0.
- load_en = !out_valid | out_ready. This gives full throughput: one flit per cycle when downstream is always ready.
- Eligible set E = req_valid, masked to only lock_idx while lock=1.
- Grant selection (combinational):
  - RR_MODE=1: first set bit of E searching from ptr upward, wrapping NUM_REQ-1 -> 0.
  - RR_MODE=0: lowest set bit of E.
- req_ready[g] = load_en & (E != 0) for granted g; all other bits 0. req_ready may depend on req_valid combinationally. Requesters must not make req_valid depend on req_ready.
- On transfer (load_en & E != 0), at the next edge:
  - out_valid=1, out_data=req_data[g], out_winner=g, out_last=req_last[g].
  - ptr = (g+1) mod NUM_REQ. The pointer updates in both RR modes but is only used when RR_MODE=1.
- On load_en with E == 0: out_valid=0 after an accept, or stays 0. out_data, out_winner and out_last hold their values.
- No load (out_valid & !out_ready): output registers, ptr and lock all hold. Stall is stable.
- Latency: a request presented in cycle t with load_en=1 appears on the outputs in cycle t+1.
- Lock (LOCK_PKT=1):
  - A transfer with req_last=0 sets lock=1, lock_idx=g.
  - A transfer with req_last=1 clears lock.
  - While locked, other requesters get no grant even if lock_idx is idle (no req_valid). No timeout.
  - ptr advances only on the tail flit transfer; a multi-flit packet counts as one turn.
- LOCK_PKT=0: lock stays 0 permanently, and out_last still passes through.
- Simultaneous requests: exactly one grant per cycle, never two. With all NUM_REQ valid continuously in RR mode, grants cycle ptr, ptr+1, ... (wrap). No requester waits more than NUM_REQ-1 transfers (LOCK_PKT=0).
- Reset mid-packet: lock is cleared and ptr returns to 0. A partially sent packet is abandoned; upstream is responsible for retransmission.
- No combinational path from out_ready to out_data, out_valid or out_winner. out_ready does feed req_ready combinationally.

Test Plan:
- Reset, then assert all 4 req_valid continuously with out_ready=1 and RR_MODE=1 -> out_winner sequence 0,1,2,3,0,1,..., one per cycle; req_ready is one-hot each cycle.
- Only req_valid[2] is high with data 0xA5 -> next cycle out_valid=1, out_data=0xA5, out_winner=2; ptr becomes 3. Then raise req 1 and 3 together -> winner 3, then 1.
- out_ready=0 for 5 cycles while out_valid=1 -> outputs constant and req_ready=0 throughout. Raise out_ready -> same-cycle accept; a new flit is loaded at the next edge.
- RR_MODE=0 with reqs 1 and 3 both continuously valid -> winner is always 1; requester 3 is starved until req 1 drops.
- LOCK_PKT=1: req0 sends a 3-flit packet (last on the 3rd flit) while req1 is valid throughout -> winners 0,0,0, then 1. If req0 idles for 2 cycles mid-packet, out_valid=0 for those cycles and req1 is still not granted.
- Assert reset during a locked packet -> next cycle all outputs are 0 and lock is cleared. With reqs 1 and 2 valid after reset, winner is 1 (ptr=0).
